// File: rtl/e1_frame_aligner.sv
// E1 receive frame aligner: hunts the 8 bit offsets of the unaligned
// converter words for the FAS, confirms it with NFAS then FAS one frame
// apart, and emits octet-aligned timeslot bytes with timeslot number and
// frame parity while in SYNC.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   byte_in          unaligned word, bit 0 earliest received
//   byte_valid       single-cycle strobe qualifying byte_in
//   ts_byte          aligned timeslot byte, bit 0 earliest
//   ts_valid         one-cycle strobe for ts_byte/ts_num/frame_odd
//   ts_num           timeslot index of ts_byte
//   frame_odd        0 for a FAS frame, 1 for an NFAS frame
//   in_sync          high while in SYNC
//   align_ofs        bit offset locked or under verification
// Optional (macro E1_FAS_ERR_CNT_EN):
//   fas_err_clr      synchronous clear of fas_err_cnt
//   fas_err_cnt      saturating count of FAS misses seen in SYNC
module e1_frame_aligner #(
    parameter int LOSS_THRESH = 3,
    parameter int FRAME_BYTES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [7:0]  ts_byte,
    output logic        ts_valid,
    output logic [4:0]  ts_num,
    output logic        frame_odd,
    output logic        in_sync,
    output logic [2:0]  align_ofs
`ifdef E1_FAS_ERR_CNT_EN
    ,
    input  logic        fas_err_clr,
    output logic [15:0] fas_err_cnt
`endif
);

    typedef enum logic [1:0] {
        HUNT,
        WAIT_NFAS,
        WAIT_FAS,
        SYNC
    } state_t;

    localparam logic [6:0] FAS_PAT = 7'b1101100;
    localparam logic [4:0] LAST    = 5'(FRAME_BYTES - 1);
    localparam logic [2:0] THRESH  = 3'(LOSS_THRESH);

    state_t      state_q, state_d;
    logic [7:0]  prev_q, prev_d;
    logic        primed_q, primed_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  err_q, err_d;
    logic        fodd_q, fodd_d;
    logic [2:0]  ofs_q, ofs_d;
    logic [7:0]  tsb_q, tsb_d;
    logic        tsv_q, tsv_d;
    logic [4:0]  tsn_q, tsn_d;
    logic        tso_q, tso_d;
    logic        sync_q, sync_d;

    logic [15:0] win;
    logic [7:0]  cand;
    logic        fas_ok;
    logic        hit_any;
    logic [2:0]  hit_ofs;
    logic        wrap;
    logic [4:0]  cnt_inc;
    logic [2:0]  err_inc;

`ifdef E1_FAS_ERR_CNT_EN
    logic        fas_miss;
    logic [15:0] fec_q, fec_d;
`endif

    always_comb begin
        win     = {byte_in, prev_q};
        cand    = win[ofs_q +: 8];
        fas_ok  = (cand[7:1] == FAS_PAT);
        hit_any = 1'b0;
        hit_ofs = 3'd0;
        // Scan high to low so the lowest matching offset wins.
        for (int k = 7; k >= 0; k--) begin
            if (win[k+1 +: 7] == FAS_PAT) begin
                hit_any = 1'b1;
                hit_ofs = 3'(k);
            end
        end
        wrap    = (cnt_q == LAST);
        cnt_inc = wrap ? 5'd0 : cnt_q + 5'd1;
        err_inc = err_q + 3'd1;
    end

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        primed_d = primed_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        fodd_d   = fodd_q;
        ofs_d    = ofs_q;
        tsb_d    = tsb_q;
        tsv_d    = 1'b0;
        tsn_d    = tsn_q;
        tso_d    = tso_q;
        sync_d   = sync_q;
`ifdef E1_FAS_ERR_CNT_EN
        fas_miss = 1'b0;
`endif
        if (byte_valid) begin
            prev_d   = byte_in;
            primed_d = 1'b1;
            unique case (state_q)
                HUNT: begin
                    if (primed_q && hit_any) begin
                        ofs_d   = hit_ofs;
                        cnt_d   = 5'd0;
                        state_d = WAIT_NFAS;
                    end
                end
                WAIT_NFAS: begin
                    cnt_d = cnt_inc;
                    if (wrap) state_d = cand[1] ? WAIT_FAS : HUNT;
                end
                WAIT_FAS: begin
                    cnt_d = cnt_inc;
                    if (wrap) begin
                        if (fas_ok) begin
                            // Confirming FAS is emitted as TS0, so the
                            // next byte is already TS1.
                            state_d = SYNC;
                            fodd_d  = 1'b0;
                            err_d   = 3'd0;
                            cnt_d   = 5'd1;
                            tsv_d   = 1'b1;
                            tsb_d   = cand;
                            tsn_d   = 5'd0;
                            tso_d   = 1'b0;
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                SYNC: begin
                    tsv_d = 1'b1;
                    tsb_d = cand;
                    tsn_d = cnt_q;
                    tso_d = fodd_q;
                    cnt_d = cnt_inc;
                    if (wrap) fodd_d = ~fodd_q;
                    if (cnt_q == 5'd0 && !fodd_q) begin
                        if (fas_ok) begin
                            err_d = 3'd0;
                        end else begin
                            err_d = err_inc;
`ifdef E1_FAS_ERR_CNT_EN
                            fas_miss = 1'b1;
`endif
                            if (err_inc >= THRESH) state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
            sync_d = (state_d == SYNC);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            prev_q   <= 8'd0;
            primed_q <= 1'b0;
            cnt_q    <= 5'd0;
            err_q    <= 3'd0;
            fodd_q   <= 1'b0;
            ofs_q    <= 3'd0;
            tsb_q    <= 8'd0;
            tsv_q    <= 1'b0;
            tsn_q    <= 5'd0;
            tso_q    <= 1'b0;
            sync_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            primed_q <= primed_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            fodd_q   <= fodd_d;
            ofs_q    <= ofs_d;
            tsb_q    <= tsb_d;
            tsv_q    <= tsv_d;
            tsn_q    <= tsn_d;
            tso_q    <= tso_d;
            sync_q   <= sync_d;
        end
    end

`ifdef E1_FAS_ERR_CNT_EN
    always_comb begin
        fec_d = fec_q;
        if (fas_err_clr) begin
            fec_d = 16'd0;
        end else if (fas_miss && fec_q != 16'hFFFF) begin
            fec_d = fec_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) fec_q <= 16'd0;
        else        fec_q <= fec_d;
    end

    assign fas_err_cnt = fec_q;
`endif

    assign ts_byte   = tsb_q;
    assign ts_valid  = tsv_q;
    assign ts_num    = tsn_q;
    assign frame_odd = tso_q;
    assign in_sync   = sync_q;
    assign align_ofs = ofs_q;

endmodule
